// File: rtl/irs_event_merge_pkg.sv
// Shared definitions for the IRS event merger: header nibble, daughter limit, FSM states.
// Imported by the merger top and its stall timer.
package irs_event_merge_pkg;

  localparam int unsigned MaxDaughters = 8;
  localparam logic [3:0]  HdrNibble    = 4'hA;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StHdr,
    StData,
    StTrl,
    StDone
  } merge_state_e;

  // Header layout: {nibble, 4-bit daughter index, 8-bit pass mask}
  function automatic logic [15:0] hdr_word(input logic [2:0] idx, input logic [7:0] mask);
    return {HdrNibble, 1'b0, idx, mask};
  endfunction

endpackage

// File: rtl/irs_event_merge_if.sv
// Bundle of the daughter readout FIFOs and the downstream event FIFO write port.
// The merger uses the master side; the surrounding fabric (or a bench) uses slave.
interface irs_event_merge_if #(
  parameter int unsigned NUM_DAUGHTERS = 4
);

  logic [16*NUM_DAUGHTERS-1:0] irs_dat;
  logic [NUM_DAUGHTERS-1:0]    irs_empty;
  logic [NUM_DAUGHTERS-1:0]    irs_done;
  logic [NUM_DAUGHTERS-1:0]    irs_rd;
  logic [15:0]                 event_dat;
  logic                        event_wr;
  logic                        event_full;

  modport master (
    input  irs_dat,
    input  irs_empty,
    input  irs_done,
    input  event_full,
    output irs_rd,
    output event_dat,
    output event_wr
  );

  modport slave (
    output irs_dat,
    output irs_empty,
    output irs_done,
    output event_full,
    input  irs_rd,
    input  event_dat,
    input  event_wr
  );

endinterface

// File: rtl/irs_merge_stall_timer.sv
// Clearable stall counter that saturates at a terminal value and flags it.
// Used to abandon a daughter that stops delivering words.
module irs_merge_stall_timer
  import irs_event_merge_pkg::*;
#(
  parameter int unsigned Width    = 16,
  parameter int unsigned Terminal = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam logic [Width-1:0] TermVal = Width'(Terminal);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != TermVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TermVal);

endmodule

// File: rtl/irs_event_merge.sv
// Merges per-daughter IRS readout FIFOs into one event stream: for each selected daughter a
// header, its data words, then a trailer holding the word count.
module irs_event_merge
  import irs_event_merge_pkg::*;
#(
  parameter int unsigned NUM_DAUGHTERS = 4,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned STALL_BITS    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     go_i,
  input  logic [NUM_DAUGHTERS-1:0] mask_i,
  irs_event_merge_if.master        irs_io,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [NUM_DAUGHTERS-1:0] err_o
);

  localparam int unsigned N = NUM_DAUGHTERS;

  merge_state_e state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] err_q, err_d;
  logic [2:0]   sel_q, sel_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [15:0]  dat_q, dat_d;
  logic         wr_q, wr_d;
  logic         done_q, done_d;

  logic [N-1:0] sel_oh;
  logic [15:0]  dat_sel;
  logic [2:0]   first_idx;
  logic [7:0]   mask8;
  logic         empty_sel, done_sel, pop;
  logic         stall_clr, stall_inc, stall_term;

  always_comb begin
    sel_oh    = '0;
    dat_sel   = '0;
    first_idx = '0;
    mask8     = '0;
    for (int k = 0; k < int'(N); k++) begin
      sel_oh[k] = (sel_q == 3'(k));
      if (sel_q == 3'(k)) begin
        dat_sel = irs_io.irs_dat[16*k +: 16];
      end
    end
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        first_idx = 3'(k);
      end
    end
    mask8[N-1:0] = mask_q;
  end

  assign empty_sel = |(irs_io.irs_empty & sel_oh);
  assign done_sel  = |(irs_io.irs_done & sel_oh);
  assign pop       = (state_q == StData) && !empty_sel && !irs_io.event_full;

  assign irs_io.irs_rd = sel_oh & {N{pop}};

  // Only genuine starvation counts; backpressure from the event FIFO holds the timer.
  assign stall_clr = (state_q != StData) || pop;
  assign stall_inc = (state_q == StData) && empty_sel && !done_sel && !irs_io.event_full;

  irs_merge_stall_timer #(
    .Width    (STALL_BITS),
    .Terminal (TIMEOUT - 1)
  ) u_stall_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (stall_clr),
    .inc_i  (stall_inc),
    .term_o (stall_term)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mask_d  = mask_q;
    err_d   = err_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          pend_d  = mask_i;
          mask_d  = mask_i;
          err_d   = '0;
          sel_d   = '0;
          state_d = StSel;
        end
      end
      StSel: begin
        if (|pend_q) begin
          sel_d   = first_idx;
          state_d = StHdr;
        end else begin
          state_d = StDone;
        end
      end
      StHdr: begin
        if (!irs_io.event_full) begin
          wr_d    = 1'b1;
          dat_d   = hdr_word(sel_q, mask8);
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (pop) begin
          wr_d  = 1'b1;
          dat_d = dat_sel;
          cnt_d = cnt_q + 16'd1;
        end else if (done_sel && empty_sel) begin
          state_d = StTrl;
        end else if (stall_inc && stall_term) begin
          err_d   = err_q | sel_oh;
          state_d = StTrl;
        end
      end
      StTrl: begin
        if (!irs_io.event_full) begin
          wr_d    = 1'b1;
          dat_d   = cnt_q;
          pend_d  = pend_q & ~sel_oh;
          state_d = StSel;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pend_q  <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  assign irs_io.event_dat = dat_q;
  assign irs_io.event_wr  = wr_q;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_irs_event_merge.sv
// Bench for irs_event_merge: daughters modelled as word arrays with random gaps and random
// event-FIFO backpressure; the output stream is compared against a list built from the mask.
module tb_irs_event_merge;

  localparam int unsigned N  = 8;
  localparam int unsigned TO = 16;

  logic         clk_i = 1'b0;
  logic         rst_i, go_i;
  logic [N-1:0] mask_i;
  logic         busy_o, done_o;
  logic [N-1:0] err_o;

  always #5 clk_i = ~clk_i;

  irs_event_merge_if #(.NUM_DAUGHTERS(N)) bus ();

  irs_event_merge #(
    .NUM_DAUGHTERS (N),
    .TIMEOUT       (TO),
    .STALL_BITS    (16)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .go_i   (go_i),
    .mask_i (mask_i),
    .irs_io (bus),
    .busy_o (busy_o),
    .done_o (done_o),
    .err_o  (err_o)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [15:0]  words [N][256];
  int           len [N];
  int           head [N];
  int           gap_run [N];
  logic [N-1:0] never_v;
  logic [15:0]  obs [$];
  logic [15:0]  exp_q [$];
  logic [N-1:0] rd_seen;
  logic         full_prev;
  bit           done_seen;
  int           full_pct;
  logic         go_next, noise_next, rst_next;
  logic [N-1:0] mask_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: account for the edge just passed, then drive inputs for the next cycle.
  task automatic step();
    logic avail;
    @(negedge clk_i);
    for (int k = 0; k < int'(N); k++) begin
      if (rd_seen[k]) begin
        check("pop_valid", 32'(head[k] < len[k]), 32'd1);
        if (head[k] < len[k]) head[k]++;
      end
    end
    if (bus.event_wr) begin
      obs.push_back(bus.event_dat);
      check("wr_after_full", 32'(full_prev), 32'd0);
    end
    if (done_o) done_seen = 1'b1;
    rst_i          = rst_next;
    go_i           = go_next | (noise_next & busy_o);
    mask_i         = mask_next;
    bus.event_full = ($urandom_range(99) < full_pct);
    for (int k = 0; k < int'(N); k++) begin
      avail = (head[k] < len[k]);
      if (avail && gap_run[k] < 3 && $urandom_range(3) == 0) begin
        gap_run[k]++;
        avail = 1'b0;
      end else begin
        gap_run[k] = 0;
      end
      bus.irs_empty[k]         = !avail;
      bus.irs_done[k]          = !never_v[k] && (head[k] >= len[k]);
      bus.irs_dat[16*k +: 16]  = avail ? words[k][head[k]] : 16'($urandom);
    end
    #1;
    rd_seen   = bus.irs_rd;
    full_prev = bus.event_full;
  endtask

  task automatic load(input int k, input int n, input bit nv);
    len[k]     = n;
    head[k]    = 0;
    gap_run[k] = 0;
    never_v[k] = nv;
    for (int i = 0; i < n; i++) words[k][i] = 16'($urandom);
  endtask

  task automatic clear_all();
    for (int k = 0; k < int'(N); k++) load(k, 0, 1'b0);
  endtask

  // Expected stream follows directly from the mask and the daughters' word lists.
  task automatic run_pass(input logic [N-1:0] m, input string tag);
    int cyc;
    exp_q.delete();
    for (int k = 0; k < int'(N); k++) begin
      if (m[k]) begin
        exp_q.push_back({4'hA, 4'(k), 8'(m)});
        for (int i = 0; i < len[k]; i++) exp_q.push_back(words[k][i]);
        exp_q.push_back(16'(len[k]));
      end
    end
    obs.delete();
    done_seen = 1'b0;
    mask_next = m;
    go_next   = 1'b1;
    step();
    go_next = 1'b0;
    cyc     = 0;
    while (!done_seen && cyc < 6000) begin
      noise_next = ($urandom_range(15) == 0);
      mask_next  = N'($urandom);
      step();
      cyc++;
    end
    noise_next = 1'b0;
    check({tag, "_done"}, 32'(done_seen), 32'd1);
    check({tag, "_err"}, 32'(err_o), 32'(m & never_v));
    check({tag, "_nwords"}, 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check({tag, "_word"}, 32'(obs[i]), 32'(exp_q[i]));
    end
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"}, 32'(bus.event_wr), 32'd0);
    check({tag, "_dat"}, 32'(bus.event_dat), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_rd"}, 32'(bus.irs_rd), 32'd0);
  endtask

  initial begin
    int lat;
    int cyc;
    rst_i = 1'b1; go_i = 1'b0; mask_i = '0;
    bus.event_full = 1'b0; bus.irs_empty = '1; bus.irs_done = '0; bus.irs_dat = '0;
    rd_seen = '0; full_prev = 1'b0; full_pct = 0;
    go_next = 1'b0; noise_next = 1'b0; rst_next = 1'b1; mask_next = '0;
    clear_all();

    repeat (3) step();
    check_reset_outputs("reset");
    rst_next = 1'b0;
    step();

    // Two daughters, clean path
    clear_all();
    load(0, 10, 1'b0);
    load(2, 3, 1'b0);
    run_pass(8'b0000_0101, "two_daughters");

    // Empty mask: SEL then DONE, no writes
    clear_all();
    obs.delete();
    done_seen = 1'b0;
    mask_next = '0;
    go_next   = 1'b1;
    step();
    go_next = 1'b0;
    lat     = 0;
    while (!done_seen && lat < 20) begin
      step();
      lat++;
    end
    check("mask0_latency", 32'(lat), 32'd3);
    check("mask0_nwords", 32'(obs.size()), 32'd0);

    // Starved daughter that never finishes
    clear_all();
    load(1, 0, 1'b1);
    run_pass(8'b0000_0010, "timeout");

    // Long readout under heavy backpressure
    clear_all();
    load(0, 200, 1'b0);
    full_pct = 50;
    run_pass(8'b0000_0001, "full_toggle");
    full_pct = 0;

    // Highest daughter alone
    clear_all();
    load(7, 1, 1'b0);
    run_pass(8'h80, "top_daughter");

    // Reset in the middle of a readout, then a fresh pass
    clear_all();
    load(0, 10, 1'b0);
    obs.delete();
    mask_next = 8'h01;
    go_next   = 1'b1;
    step();
    go_next = 1'b0;
    cyc     = 0;
    while (obs.size() < 6 && cyc < 200) begin
      step();
      cyc++;
    end
    check("midreset_reached", 32'(obs.size()), 32'd6);
    rst_next = 1'b1;
    go_next  = 1'b1;
    step();
    go_next  = 1'b0;
    rst_next = 1'b0;
    step();
    check_reset_outputs("midreset");
    clear_all();
    load(0, 4, 1'b0);
    run_pass(8'h01, "after_reset");

    // Random passes
    for (int p = 0; p < 12; p++) begin
      clear_all();
      for (int k = 0; k < int'(N); k++) begin
        load(k, int'($urandom_range(8)), ($urandom_range(9) == 0));
      end
      full_pct = (p % 3 == 0) ? 0 : ((p % 3 == 1) ? 25 : 60);
      run_pass(N'($urandom), "random");
    end
    full_pct = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
